// File: rtl/jtag_types_pkg.sv
// Shared JTAG types.
//   state_t        : 16-state IEEE 1149.1 TAP controller state
//   jtag_cmd_t     : scan-master command encoding
//   mstate_t       : scan-master sequencing state
//   TLR_RESET_BITS : TMS=1 bits that force any TAP into Test-Logic-Reset
//   tap_next()     : standard TAP transition on one TMS bit
package jtag_types_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } state_t;

  typedef enum logic [1:0] {
    CMD_RESET   = 2'd0,
    CMD_SCAN_IR = 2'd1,
    CMD_SCAN_DR = 2'd2,
    CMD_IDLE    = 2'd3
  } jtag_cmd_t;

  typedef enum logic [2:0] {
    M_IDLE, M_PRE, M_NAV_IN, M_SHIFT, M_NAV_OUT, M_RSP
  } mstate_t;

  localparam int TLR_RESET_BITS = 5;

  function automatic state_t tap_next(state_t s, logic tms);
    state_t n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_scan_master_tck_gen.sv
// JTAG clock generator. While run is high it produces a TCK_OUT of
// DIV low cycles followed by DIV high cycles, with strobes:
//   fall_stb : first cycle of the low phase (bit start)
//   rise_stb : last low cycle; the edge ending it raises tck (TDO sample)
//   end_stb  : last high cycle (bit end)
// With run low the generator parks at tck=0, start of a low phase.
// Ports: clk, rst (async high), run -> tck, fall_stb, rise_stb, end_stb.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb,
  output logic end_stb
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt;
  logic          last;

  assign last     = (cnt == LAST);
  assign fall_stb = run && !tck && (cnt == '0);
  assign rise_stb = run && !tck && last;
  assign end_stb  = run &&  tck && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan master. Turns RESET / IR scan / DR scan / IDLE
// commands into TMS/TDI bit sequences on TCK_OUT, captures TDO during
// shift bits and mirrors the target TAP state.
// Ports:
//   TCK, TRST (async high)           system clock / reset
//   cmd_valid/ready/type/len/data    command request
//   rsp_valid/ready/data             response (captured TDO bits)
//   busy, tap_state                  status
//   TCK_OUT, TMS, TDI, TDO           JTAG pins
//   TRST_OUT (only with JTAG_TRST_OUT_EN) active-low target reset
module jtag_scan_master
  import jtag_types_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2
) (
  input  logic                         TCK,
  input  logic                         TRST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  jtag_cmd_t                    cmd_type,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         busy,
  output state_t                       tap_state,
  output logic                         TCK_OUT,
  output logic                         TMS,
  output logic                         TDI,
  input  logic                         TDO
`ifdef JTAG_TRST_OUT_EN
  ,
  output logic                         TRST_OUT
`endif
);

  localparam int LW = $clog2(MAX_LEN + 1);
  // bit counter also walks the 6-bit reset preamble
  localparam int CW = (LW < 3) ? 3 : LW;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  mstate_t            mstate, m_nx;
  cnt_t               cnt, cnt_nx;
  jtag_cmd_t          ctype, typ_nx;
  cnt_t               clen, len_nx;
  logic [MAX_LEN-1:0] cdata, data_nx;
  logic [MAX_LEN-1:0] smp_mask, rsp;
  logic               tms_q, tdi_q, accept, run;
  logic               fall_stb, rise_stb, end_stb;
  state_t             tap_q;

  function automatic logic is_active(mstate_t m);
    return (m == M_PRE) || (m == M_NAV_IN) || (m == M_SHIFT) || (m == M_NAV_OUT);
  endfunction

  // Scans run at least one bit; everything is clamped to MAX_LEN.
  function automatic cnt_t eff_len(jtag_cmd_t t, logic [LW-1:0] l);
    cnt_t n;
    n = (l > LW'(MAX_LEN)) ? cnt_t'(MAX_LEN) : cnt_t'(l);
    if (n == '0 && t != CMD_IDLE) n = ONE;
    return n;
  endfunction

  // Bits spent getting from Run-Test/Idle to the shift state (or the
  // whole sequence for RESET / IDLE).
  function automatic cnt_t nav_len(jtag_cmd_t t, cnt_t n);
    cnt_t r;
    case (t)
      CMD_RESET:   r = cnt_t'(TLR_RESET_BITS + 1);
      CMD_SCAN_IR: r = cnt_t'(4);
      CMD_SCAN_DR: r = cnt_t'(3);
      default:     r = n;
    endcase
    return r;
  endfunction

  function automatic logic bit_tms(mstate_t m, cnt_t c, jtag_cmd_t t, cnt_t n);
    logic v;
    case (m)
      M_NAV_IN: begin
        case (t)
          CMD_RESET:   v = (c < cnt_t'(TLR_RESET_BITS));
          CMD_SCAN_IR: v = (c < cnt_t'(2));
          CMD_SCAN_DR: v = (c == '0);
          default:     v = 1'b0;
        endcase
      end
      M_SHIFT:   v = (c == n - ONE);
      M_NAV_OUT: v = (c == '0);
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic bit_tdi(mstate_t m, cnt_t c, logic [MAX_LEN-1:0] d);
    logic [MAX_LEN-1:0] s;
    s = d >> c;
    return (m == M_SHIFT) && s[0];
  endfunction

  assign run = is_active(mstate);

  jtag_tck_gen #(.DIV(DIV)) u_tck (
    .clk      (TCK),
    .rst      (TRST),
    .run      (run),
    .tck      (TCK_OUT),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb),
    .end_stb  (end_stb)
  );

  // State register
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      mstate <= M_IDLE;
      cnt    <= '0;
    end else begin
      mstate <= m_nx;
      cnt    <= cnt_nx;
    end
  end

  // Next position in the bit sequence. cnt is the bit index inside the
  // current segment; positions advance only at the end of a high phase.
  always_comb begin
    m_nx    = mstate;
    cnt_nx  = cnt;
    accept  = 1'b0;
    typ_nx  = ctype;
    len_nx  = clen;
    data_nx = cdata;
    case (mstate)
      M_IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        typ_nx  = cmd_type;
        len_nx  = eff_len(cmd_type, cmd_len);
        data_nx = cmd_data;
        cnt_nx  = '0;
        if (tap_q == TEST_LOGIC_RESET && cmd_type != CMD_RESET) m_nx = M_PRE;
        else if (nav_len(cmd_type, len_nx) == '0)               m_nx = M_RSP;
        else                                                    m_nx = M_NAV_IN;
      end
      M_PRE: if (end_stb) begin
        m_nx = (nav_len(ctype, clen) == '0) ? M_RSP : M_NAV_IN;
      end
      M_NAV_IN: if (end_stb) begin
        if (cnt == nav_len(ctype, clen) - ONE) begin
          cnt_nx = '0;
          m_nx   = (ctype == CMD_SCAN_IR || ctype == CMD_SCAN_DR) ? M_SHIFT : M_RSP;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      M_SHIFT: if (end_stb) begin
        if (cnt == clen - ONE) begin
          cnt_nx = '0;
          m_nx   = M_NAV_OUT;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      M_NAV_OUT: if (end_stb) begin
        if (cnt == ONE) begin
          cnt_nx = '0;
          m_nx   = M_RSP;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      M_RSP: if (rsp_ready) m_nx = M_IDLE;
      default: m_nx = M_IDLE;
    endcase
  end

  // Datapath. TMS/TDI are loaded on the edge that opens a bit, so they
  // are valid from its first low cycle. The sample mask is latched at bit
  // start so the TDO capture itself is a plain OR.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ctype    <= CMD_RESET;
      clen     <= '0;
      cdata    <= '0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      tap_q    <= TEST_LOGIC_RESET;
      smp_mask <= '0;
      rsp      <= '0;
    end else begin
      ctype <= typ_nx;
      clen  <= len_nx;
      cdata <= data_nx;
      if ((accept || end_stb) && is_active(m_nx)) begin
        tms_q <= bit_tms(m_nx, cnt_nx, typ_nx, len_nx);
        tdi_q <= bit_tdi(m_nx, cnt_nx, data_nx);
      end
      if (end_stb) tap_q <= tap_next(tap_q, tms_q);
      if (fall_stb)
        smp_mask <= (mstate == M_SHIFT) ? ({{(MAX_LEN-1){1'b0}}, 1'b1} << cnt) : '0;
      if (accept)                rsp <= '0;
      else if (rise_stb && TDO)  rsp <= rsp | smp_mask;
    end
  end

  assign cmd_ready = (mstate == M_IDLE);
  assign rsp_valid = (mstate == M_RSP);
  assign rsp_data  = rsp;
  assign busy      = (mstate != M_IDLE);
  assign tap_state = tap_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

`ifdef JTAG_TRST_OUT_EN
  assign TRST_OUT = ~(TRST | (run && ctype == CMD_RESET));
`endif

endmodule

// File: tb/tb_jtag_scan_master.sv
// Testbench for jtag_scan_master: directed table, randomized commands
// against a bit-sequence reference model, and reset/back-pressure corners.
module tb_jtag_scan_master;
  import jtag_types_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int DIV     = 2;

  logic              TCK = 1'b0;
  logic              TRST;
  logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  jtag_cmd_t         cmd_type;
  logic [5:0]        cmd_len;
  logic [31:0]       cmd_data, rsp_data;
  state_t            tap_state;
  logic              TCK_OUT, TMS, TDI, TDO;
`ifdef JTAG_TRST_OUT_EN
  logic              TRST_OUT;
`endif

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
    .TCK(TCK), .TRST(TRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tap_state(tap_state),
    .TCK_OUT(TCK_OUT), .TMS(TMS), .TDI(TDI), .TDO(TDO)
`ifdef JTAG_TRST_OUT_EN
    , .TRST_OUT(TRST_OUT)
`endif
  );

  always #5 TCK = ~TCK;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input string what, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // Pin monitor: TMS/TDI seen at every TCK_OUT rising edge.
  bit mon_tms[0:4095];
  bit mon_tdi[0:4095];
`ifdef JTAG_TRST_OUT_EN
  bit mon_trst[0:4095];
`endif
  int mon_n = 0;
  always @(posedge TCK_OUT) begin
    if (mon_n < 4096) begin
      mon_tms[mon_n] = TMS;
      mon_tdi[mon_n] = TDI;
`ifdef JTAG_TRST_OUT_EN
      mon_trst[mon_n] = TRST_OUT;
`endif
    end
    mon_n++;
  end

  // Target model: loopback of TDI, or a random bit stream indexed by the
  // JTAG clock number within the command.
  int          base = 0;
  bit          tdo_mode = 1'b0;
  logic [127:0] pat = '0;
  assign TDO = tdo_mode ? pat[7'(mon_n - base)] : TDI;

  // Reference model: expected TMS/TDI per JTAG clock and response.
  bit          e_tms[0:127];
  bit          e_tdi[0:127];
  int          e_n;
  logic [31:0] e_rsp;
  bit          tlr_exp;

  task automatic push(input bit a, input bit b);
    e_tms[e_n] = a;
    e_tdi[e_n] = b;
    e_n++;
  endtask

  task automatic model(input jtag_cmd_t t, input int len, input logic [31:0] d, input bit tlr,
                       input bit mode, input logic [127:0] p);
    int n, st;
    e_n   = 0;
    e_rsp = '0;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    if (tlr && t != CMD_RESET) push(0, 0);
    case (t)
      CMD_RESET:   begin repeat (5) push(1, 0); push(0, 0); end
      CMD_SCAN_IR: begin push(1, 0); push(1, 0); push(0, 0); push(0, 0); end
      CMD_SCAN_DR: begin push(1, 0); push(0, 0); push(0, 0); end
      default:     for (int i = 0; i < n; i++) push(0, 0);
    endcase
    if (t == CMD_SCAN_IR || t == CMD_SCAN_DR) begin
      if (n == 0) n = 1;
      st = e_n;
      for (int k = 0; k < n; k++) begin
        push(k == n - 1, d[k]);
        e_rsp[k] = mode ? p[st + k] : d[k];
      end
      push(1, 0);
      push(0, 0);
    end
  endtask

  task automatic do_cmd(input string tag, input jtag_cmd_t t, input int len, input logic [31:0] d,
                        input bit mode, input int hold, output int got_n, output logic [31:0] got_rsp);
    int lat, start_n, bad;
    logic [127:0] gt, gd, et, ed;
    logic [31:0] held;
    model(t, len, d, tlr_exp, mode, pat);
    @(negedge TCK);
    chk(tag, "ready", 128'(cmd_ready), 128'(1));
    start_n   = mon_n;
    base      = mon_n;
    tdo_mode  = mode;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = 6'(len);
    cmd_data  = d;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(posedge TCK); #1;
      lat++;
    end
    chk(tag, "latency", 128'(lat), 128'(e_n * 2 * DIV));
    got_n = mon_n - start_n;
    chk(tag, "edges", 128'(got_n), 128'(e_n));
    gt = '0; gd = '0; et = '0; ed = '0;
    for (int i = 0; i < e_n; i++) begin et[i] = e_tms[i]; ed[i] = e_tdi[i]; end
    for (int i = 0; i < got_n && i < 128; i++) begin
      gt[i] = mon_tms[start_n + i];
      gd[i] = mon_tdi[start_n + i];
    end
    chk(tag, "tms_seq", gt, et);
    chk(tag, "tdi_seq", gd, ed);
    got_rsp = rsp_data;
    chk(tag, "rsp_data", 128'(rsp_data), 128'(e_rsp));
    chk(tag, "tap_state", 128'(tap_state), 128'(RUN_TEST_IDLE));
    chk(tag, "tck_low", 128'(TCK_OUT), 128'(0));
    if (e_n > 0) chk(tag, "tms_hold", 128'(TMS), 128'(e_tms[e_n - 1]));
`ifdef JTAG_TRST_OUT_EN
    bad = 0;
    for (int i = 0; i < got_n; i++)
      if (mon_trst[start_n + i] != (t != CMD_RESET)) bad++;
    chk(tag, "trst_out_seq", 128'(bad), 128'(0));
    chk(tag, "trst_out_after", 128'(TRST_OUT), 128'(1));
`endif
    if (hold > 0) begin
      held = rsp_data;
      bad  = 0;
      repeat (hold) begin
        @(negedge TCK);
        if (!rsp_valid || rsp_data !== held || cmd_ready || !busy) bad++;
      end
      chk(tag, "hold_stable", 128'(bad), 128'(0));
    end
    @(negedge TCK);
    rsp_ready = 1'b1;
    @(posedge TCK); #1;
    rsp_ready = 1'b0;
    chk(tag, "rsp_drop", 128'(rsp_valid), 128'(0));
    tlr_exp = 1'b0;
  endtask

  typedef struct {
    jtag_cmd_t   t;
    int          len;
    logic [31:0] d;
    int          edges;
    logic [31:0] rsp;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int gn;
    logic [31:0] gr;
    jtag_cmd_t rt;

    tbl[0] = '{CMD_RESET,   0,  32'h0,        6,  32'h0};
    tbl[1] = '{CMD_SCAN_IR, 4,  32'hA,        10, 32'hA};
    tbl[2] = '{CMD_SCAN_DR, 32, 32'hDEADBEEF, 37, 32'hDEADBEEF};
    tbl[3] = '{CMD_IDLE,    0,  32'h0,        0,  32'h0};
    tbl[4] = '{CMD_IDLE,    3,  32'h0,        3,  32'h0};
    tbl[5] = '{CMD_SCAN_DR, 0,  32'h3,        6,  32'h1};
    tbl[6] = '{CMD_SCAN_IR, 40, 32'hFFFF0000, 38, 32'hFFFF0000};
    tbl[7] = '{CMD_SCAN_DR, 5,  32'hFFFFFFFF, 10, 32'h1F};
    tbl[8] = '{CMD_IDLE,    63, 32'h0,        32, 32'h0};

    TRST = 1'b1; cmd_valid = 1'b0; cmd_type = CMD_RESET; cmd_len = '0;
    cmd_data = '0; rsp_ready = 1'b0;
    #23;
    chk("reset", "tck_out",   128'(TCK_OUT),   128'(0));
    chk("reset", "tms",       128'(TMS),       128'(1));
    chk("reset", "tdi",       128'(TDI),       128'(0));
    chk("reset", "cmd_ready", 128'(cmd_ready), 128'(1));
    chk("reset", "rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset", "rsp_data",  128'(rsp_data),  128'(0));
    chk("reset", "busy",      128'(busy),      128'(0));
    chk("reset", "tap_state", 128'(tap_state), 128'(TEST_LOGIC_RESET));
`ifdef JTAG_TRST_OUT_EN
    chk("reset", "trst_out",  128'(TRST_OUT),  128'(0));
`endif
    @(negedge TCK); TRST = 1'b0;
    tlr_exp = 1'b1;

    // Directed table, TDO looped back to TDI.
    for (int i = 0; i < 9; i++) begin
      do_cmd($sformatf("tbl%0d", i), tbl[i].t, tbl[i].len, tbl[i].d, 1'b0, 0, gn, gr);
      chk($sformatf("tbl%0d", i), "tbl_edges", 128'(gn), 128'(tbl[i].edges));
      chk($sformatf("tbl%0d", i), "tbl_rsp",   128'(gr), 128'(tbl[i].rsp));
    end

    // Random commands, random TDO stream.
    for (int i = 0; i < 24; i++) begin
      rt  = jtag_cmd_t'(2'($urandom_range(0, 3)));
      pat = {$urandom, $urandom, $urandom, $urandom};
      do_cmd($sformatf("rnd%0d", i), rt, int'($urandom_range(0, 40)), $urandom, 1'b1, 0, gn, gr);
    end

    // Scan straight after reset: leading TMS=0 bit, response held 10 cycles.
    @(negedge TCK); TRST = 1'b1;
    @(negedge TCK); TRST = 1'b0;
    tlr_exp = 1'b1;
    pat = {$urandom, $urandom, $urandom, $urandom};
    do_cmd("tlr_dr", CMD_SCAN_DR, 8, 32'h5A, 1'b1, 10, gn, gr);
    chk("tlr_dr", "edges_const", 128'(gn), 128'(14));

    // Reset in the middle of a 32-bit DR scan.
    @(negedge TCK);
    cmd_valid = 1'b1; cmd_type = CMD_SCAN_DR; cmd_len = 6'd32; cmd_data = 32'h12345678;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    repeat (40) @(posedge TCK);
    @(negedge TCK);
    chk("abort", "busy_before", 128'(busy), 128'(1));
    TRST = 1'b1;
    #1;
    chk("abort", "tck_out",   128'(TCK_OUT),   128'(0));
    chk("abort", "tms",       128'(TMS),       128'(1));
    chk("abort", "tap_state", 128'(tap_state), 128'(TEST_LOGIC_RESET));
    chk("abort", "rsp_valid", 128'(rsp_valid), 128'(0));
`ifdef JTAG_TRST_OUT_EN
    chk("abort", "trst_out",  128'(TRST_OUT),  128'(0));
`endif
    @(negedge TCK); TRST = 1'b0;
    gn = 0;
    repeat (50) begin
      @(negedge TCK);
      if (rsp_valid || !cmd_ready || busy) gn++;
    end
    chk("abort", "no_response", 128'(gn), 128'(0));
    tlr_exp = 1'b1;
    do_cmd("post_abort", CMD_IDLE, 2, 32'h0, 1'b0, 0, gn, gr);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
